etapa_desplazamiento_vectorial: RTL and testbench

Sequencing stage that applies one circular-shift operation to every 8-bit element of a vector operand, one lane per cycle. It sits directly upstream of the 8-bit circular-shift unit `desplazamiento_circular`. The stage accepts a packed vector, direction and amount over a valid/ready handshake, drives the shift unit lane by lane, collects each result, and presents the rotated vector over a second valid/ready handshake.

---
 rtl/etapa_desplazamiento_vectorial_if.sv | 24 ++
 rtl/etapa_desplazamiento_vectorial.sv | 147 ++++++++++++++
 tb/tb_etapa_desplazamiento_vectorial.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/etapa_desplazamiento_vectorial_if.sv
// Operand and result handshake bundle for the vector rotate stage.
// The stage is the slave; the producer/consumer side is the master.
interface etapa_desplazamiento_vectorial_if #(
  parameter int LANES = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_vector;
  logic               in_select;
  logic [2:0]         in_amount;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_vector;

  modport master (
    output in_valid, in_vector, in_select, in_amount, out_ready,
    input  in_ready, out_valid, out_vector
  );

  modport slave (
    input  in_valid, in_vector, in_select, in_amount, out_ready,
    output in_ready, out_valid, out_vector
  );
endinterface

// File: rtl/etapa_desplazamiento_vectorial.sv
// Walks a captured vector through the external 8-bit rotate unit one lane per
// cycle, collects the lanes and offers the rotated vector on a valid/ready port.
module etapa_desplazamiento_vectorial #(
  parameter int LANES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  etapa_desplazamiento_vectorial_if.slave bus,
  output logic                            rot_select,
  output logic [7:0]                      rot_ent1,
  output logic [2:0]                      rot_ent2,
  input  logic [7:0]                      rot_result,
  output logic                            busy
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VEC_W = 8 * LANES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [VEC_W-1:0]   operand_r;
  logic [VEC_W-1:0]   result_r;
  logic               sel_r;
  logic [2:0]         amt_r;
  logic               capture_s;
  logic [IDX_W+2:0]   next_base_s;
  logic [IDX_W+2:0]   cur_base_s;
  logic               in_ready_r, in_ready_s;
  logic               out_valid_r, out_valid_s;
  logic               busy_r, busy_s;
  logic               rot_select_r, rot_select_s;
  logic [7:0]         rot_ent1_r, rot_ent1_s;
  logic [2:0]         rot_ent2_r, rot_ent2_s;

  assign cur_base_s  = {idx_r, 3'b000};
  assign next_base_s = {idx_r + IDX_W'(1), 3'b000};

  // Next state plus next value of every registered output; the rotate-unit
  // drive is prefetched one cycle ahead so the lane is ready on entering it.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    capture_s    = 1'b0;
    rot_select_s = 1'b0;
    rot_ent1_s   = 8'h00;
    rot_ent2_s   = 3'd0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s      = RUN;
          idx_s        = {IDX_W{1'b0}};
          capture_s    = 1'b1;
          rot_select_s = bus.in_select;
          rot_ent1_s   = bus.in_vector[7:0];
          rot_ent2_s   = bus.in_amount;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          idx_s        = idx_r + IDX_W'(1);
          rot_select_s = sel_r;
          rot_ent1_s   = operand_r[next_base_s +: 8];
          rot_ent2_s   = amt_r;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
    busy_s      = (state_s != IDLE);
  end

  // State, lane index and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= {IDX_W{1'b0}};
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      rot_select_r <= 1'b0;
      rot_ent1_r   <= 8'h00;
      rot_ent2_r   <= 3'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      in_ready_r   <= in_ready_s;
      out_valid_r  <= out_valid_s;
      busy_r       <= busy_s;
      rot_select_r <= rot_select_s;
      rot_ent1_r   <= rot_ent1_s;
      rot_ent2_r   <= rot_ent2_s;
    end
  end

  // Operand and command capture on the accepting edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_r <= {VEC_W{1'b0}};
      sel_r     <= 1'b0;
      amt_r     <= 3'd0;
    end else if (capture_s) begin
      operand_r <= bus.in_vector;
      sel_r     <= bus.in_select;
      amt_r     <= bus.in_amount;
    end
  end

  // Result lanes; unwritten lanes keep the previous operation's value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= {VEC_W{1'b0}};
    end else if (state_r == RUN) begin
      result_r[cur_base_s +: 8] <= rot_result;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_vector = result_r;
  assign busy           = busy_r;
  assign rot_select     = rot_select_r;
  assign rot_ent1       = rot_ent1_r;
  assign rot_ent2       = rot_ent2_r;

endmodule

// File: tb/tb_etapa_desplazamiento_vectorial.sv
// Directed and randomised bench for the vector rotate stage with a stand-in
// rotate unit and a queue-based reference model checked on every cycle.
module tb_etapa_desplazamiento_vectorial;

  localparam int LANES = 4;
  localparam int VW    = 8 * LANES;
  localparam logic [VW-1:0] OP = 32'h3CF0_0181;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  etapa_desplazamiento_vectorial_if #(.LANES(LANES)) bus ();
  logic       rot_select;
  logic [7:0] rot_ent1;
  logic [2:0] rot_ent2;
  logic [7:0] rot_result;
  logic       busy;

  etapa_desplazamiento_vectorial #(.LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rot_select (rot_select),
    .rot_ent1   (rot_ent1),
    .rot_ent2   (rot_ent2),
    .rot_result (rot_result),
    .busy       (busy)
  );

  function automatic logic [7:0] rot8(input logic [7:0] x, input logic r, input logic [2:0] n);
    logic [15:0] t;
    if (r) begin
      t = {x, x} >> n;
      return t[7:0];
    end else begin
      t = {x, x} << n;
      return t[15:8];
    end
  endfunction

  function automatic logic [VW-1:0] rot_vec(input logic [VW-1:0] v, input logic r, input logic [2:0] n);
    logic [VW-1:0] o;
    for (int i = 0; i < LANES; i++) o[i*8 +: 8] = rot8(v[i*8 +: 8], r, n);
    return o;
  endfunction

  // external rotate unit stand-in
  assign rot_result = rot8(rot_ent1, rot_select, rot_ent2);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: 0 idle, 1 running, 2 result offered
  int            phase = 0;
  int            lanes_left = 0;
  logic [VW-1:0] cur_op;
  logic          cur_sel;
  logic [2:0]    cur_amt;
  logic [VW-1:0] exp_q[$];
  int            n_acc = 0;
  int            n_del = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rot", 64'({rot_select, rot_ent1, rot_ent2}), 64'd0);
        chk("rst_out_vector", 64'(bus.out_vector), 64'd0);
        phase = 0;
        exp_q.delete();
      end else begin
        chk("in_ready", 64'(bus.in_ready), 64'(phase == 0));
        chk("out_valid", 64'(bus.out_valid), 64'(phase == 2));
        chk("busy", 64'(busy), 64'(phase != 0));
        case (phase)
          0: begin
            chk("rot_idle", 64'({rot_select, rot_ent1, rot_ent2}), 64'd0);
            if (bus.in_valid) begin
              cur_op  = bus.in_vector;
              cur_sel = bus.in_select;
              cur_amt = bus.in_amount;
              exp_q.push_back(rot_vec(bus.in_vector, bus.in_select, bus.in_amount));
              lanes_left = LANES;
              phase = 1;
              n_acc++;
            end
          end
          1: begin
            chk("rot_ent1", 64'(rot_ent1), 64'(cur_op[(LANES-lanes_left)*8 +: 8]));
            chk("rot_ent2", 64'(rot_ent2), 64'(cur_amt));
            chk("rot_select", 64'(rot_select), 64'(cur_sel));
            lanes_left--;
            if (lanes_left == 0) phase = 2;
          end
          default: begin
            chk("rot_done", 64'({rot_select, rot_ent1, rot_ent2}), 64'd0);
            chk("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("out_vector", 64'(bus.out_vector), 64'(exp_q[0]));
            if (bus.out_ready) begin
              if (exp_q.size() > 0) void'(exp_q.pop_front());
              n_del++;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic send(input logic [VW-1:0] v, input logic s, input logic [2:0] a);
    int n;
    @(posedge clk); #1;
    bus.in_vector = v;
    bus.in_select = s;
    bus.in_amount = a;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  int  cyc;
  int  acc0, del0;
  bit  stream_done;
  logic [VW-1:0] held;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vector = '0;
    bus.in_select = 1'b0;
    bus.in_amount = 3'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_vector", 64'(bus.out_vector), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    // pin the model to hand-computed values
    chk("model_right1", 64'(rot_vec(OP, 1'b1, 3'd1)), 64'h1E78_80C0);
    chk("model_left3", 64'(rot_vec(OP, 1'b0, 3'd3)), 64'hE187_080C);
    chk("model_amt0", 64'(rot_vec(OP, 1'b0, 3'd0)), 64'h3CF0_0181);

    // right rotate by 1, latency from accept
    send(OP, 1'b1, 3'd1);
    wait_out(cyc);
    chk("latency", 64'(cyc), 64'(LANES));
    chk("right1", 64'(bus.out_vector), 64'h1E78_80C0);

    send(OP, 1'b0, 3'd3);
    wait_out(cyc);
    chk("left3", 64'(bus.out_vector), 64'hE187_080C);

    send(OP, 1'b0, 3'd0);
    wait_out(cyc);
    chk("amt0", 64'(bus.out_vector), 64'h3CF0_0181);

    // back-pressure with ignored input pulses
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(OP, 1'b1, 3'd1);
    wait_out(cyc);
    held = bus.out_vector;
    chk("bp_first", 64'(held), 64'h1E78_80C0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = ~bus.in_valid;
      bus.in_vector = $urandom;
      bus.in_amount = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      chk("bp_stable", 64'(bus.out_vector), 64'h1E78_80C0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // reset while lane 2 is in flight
    send(32'hA5A5_5A5A, 1'b1, 3'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_vector", 64'(bus.out_vector), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(OP, 1'b0, 3'd3);
    wait_out(cyc);
    chk("after_rst", 64'(bus.out_vector), 64'hE187_080C);

    // inputs churn during the run
    send(OP, 1'b1, 3'd1);
    for (int i = 0; i < LANES; i++) begin
      bus.in_vector = $urandom;
      bus.in_amount = 3'($urandom_range(0, 7));
      bus.in_select = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    wait_out(cyc);
    chk("stability", 64'(bus.out_vector), 64'h1E78_80C0);

    // random stream with random back-pressure
    @(posedge clk); #1;
    acc0 = n_acc;
    del0 = n_del;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((phase != 0 || exp_q.size() != 0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_accepted", 64'(n_acc - acc0), 64'd50);
    chk("stream_delivered", 64'(n_del - del0), 64'd50);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
